md5_arbiter: RTL and testbench

MD5_ARBITER -- requirements
Module: md5_arbiter

---
 rtl/md5_pkg.sv | 32 +++
 rtl/md5_arbiter_if.sv | 38 +++
 rtl/rr_pick.sv | 31 +++
 rtl/md5_arbiter.sv | 144 ++++++++++++++
 tb/tb_md5_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/md5_pkg.sv
// Shared types and widths for the MD5 requester arbiter.
package md5_pkg;

    localparam int unsigned MD5_MSG_W   = 128;
    localparam int unsigned MD5_HASH_W  = 128;
    localparam int unsigned MD5_WIDTH_W = 8;
    localparam int unsigned MD5_ID_W    = 3;
    localparam int unsigned MD5_CNT_W   = 32;
    localparam int unsigned MD5_MAX_REQ = 1 << MD5_ID_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } md5_state_e;

    typedef struct packed {
        logic [MD5_MSG_W-1:0]   msg;
        logic [MD5_WIDTH_W-1:0] width;
    } md5_job_t;

    // Round-robin pointer advance past the requester just served.
    function automatic logic [MD5_ID_W-1:0] next_ptr(input logic [MD5_ID_W-1:0] tag,
                                                    input int unsigned          nreq);
        int unsigned nxt;
        nxt = 32'(tag) + 32'd1;
        if (nxt >= nreq) nxt = 0;
        return MD5_ID_W'(nxt);
    endfunction

endpackage

// File: rtl/md5_arbiter_if.sv
// Requester, core and result bundle of the MD5 arbiter.
interface md5_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    import md5_pkg::*;

    logic [NREQ-1:0]             req_valid;
    logic [NREQ*MD5_MSG_W-1:0]   req_msg;
    logic [NREQ*MD5_WIDTH_W-1:0] req_width;
    logic [NREQ-1:0]             req_ready;

    logic [MD5_MSG_W-1:0]        core_msg;
    logic [MD5_WIDTH_W-1:0]      core_width;
    logic                        core_valid;
    logic                        core_ready;
    logic [MD5_HASH_W-1:0]       core_hash;
    logic                        core_hash_valid;

    logic                        res_valid;
    logic [MD5_HASH_W-1:0]       res_hash;
    logic [MD5_ID_W-1:0]         res_id;
    logic                        res_ready;
    logic                        res_timeout;
    logic [MD5_CNT_W-1:0]        jobs_done;

    modport master (
        output req_valid, req_msg, req_width, core_ready, core_hash, core_hash_valid, res_ready,
        input  req_ready, core_msg, core_width, core_valid, res_valid, res_hash, res_id,
               res_timeout, jobs_done
    );

    modport slave (
        input  req_valid, req_msg, req_width, core_ready, core_hash, core_hash_valid, res_ready,
        output req_ready, core_msg, core_width, core_valid, res_valid, res_hash, res_id,
               res_timeout, jobs_done
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, modulo NREQ.
module rr_pick
    import md5_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]     req,
    input  logic [MD5_ID_W-1:0] ptr,
    output logic [MD5_ID_W-1:0] grant,
    output logic                any_valid
);

    logic [MD5_MAX_REQ-1:0] req_ext;
    assign req_ext = MD5_MAX_REQ'(req);

    // Scan from farthest to nearest so the nearest hit wins.
    always_comb begin
        int unsigned idx;
        grant     = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            idx = (32'(ptr) + 32'(i)) % NREQ;
            if (req_ext[MD5_ID_W'(idx)]) begin
                grant     = MD5_ID_W'(idx);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/md5_arbiter.sv
// Shares one MD5 core among NREQ requesters, one job in flight, round-robin grant.
// Optional WAIT timeout is enabled by defining MD5_ARB_TIMEOUT_EN.
module md5_arbiter
    import md5_pkg::*;
#(
    parameter int unsigned NREQ           = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic          clk,
    input logic          reset_n,
    md5_arbiter_if.slave bus
);

    md5_state_e             state;
    logic [MD5_ID_W-1:0]    rr_ptr;
    logic [MD5_ID_W-1:0]    tag;
    logic [MD5_ID_W-1:0]    pick;
    logic                   any_valid;
    md5_job_t               core_job;
    logic                   core_valid_q;
    logic [NREQ-1:0]        req_ready_q;
    logic                   res_valid_q;
    logic [MD5_HASH_W-1:0]  res_hash_q;
    logic [MD5_ID_W-1:0]    res_id_q;
    logic [MD5_CNT_W-1:0]   jobs_q;

    logic [MD5_MSG_W-1:0]   msg_arr   [MD5_MAX_REQ];
    logic [MD5_WIDTH_W-1:0] width_arr [MD5_MAX_REQ];

    // Unpack the flat request buses; unused slots read as zero.
    for (genvar g = 0; g < int'(MD5_MAX_REQ); g++) begin : g_unpack
        if (g < int'(NREQ)) begin : g_used
            assign msg_arr[g]   = bus.req_msg[g*MD5_MSG_W +: MD5_MSG_W];
            assign width_arr[g] = bus.req_width[g*MD5_WIDTH_W +: MD5_WIDTH_W];
        end else begin : g_pad
            assign msg_arr[g]   = '0;
            assign width_arr[g] = '0;
        end
    end

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req       (bus.req_valid),
        .ptr       (rr_ptr),
        .grant     (pick),
        .any_valid (any_valid)
    );

`ifdef MD5_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             timed_out;
    assign bus.res_timeout = timed_out;
`else
    logic unused_cfg;
    assign unused_cfg      = |32'(TIMEOUT_CYCLES);
    assign bus.res_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            tag          <= '0;
            core_job     <= '0;
            core_valid_q <= 1'b0;
            req_ready_q  <= '0;
            res_valid_q  <= 1'b0;
            res_hash_q   <= '0;
            res_id_q     <= '0;
            jobs_q       <= '0;
`ifdef MD5_ARB_TIMEOUT_EN
            wait_cnt     <= '0;
            timed_out    <= 1'b0;
`endif
        end else begin
            req_ready_q  <= '0;
            core_valid_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.core_ready && any_valid) begin
                        core_job    <= '{msg: msg_arr[pick], width: width_arr[pick]};
                        tag         <= pick;
                        req_ready_q <= NREQ'(1) << pick;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    core_valid_q <= 1'b1;
`ifdef MD5_ARB_TIMEOUT_EN
                    wait_cnt     <= '0;
`endif
                    state        <= WAIT;
                end
                WAIT: begin
                    // A digest in the expiry cycle still wins over the timeout.
                    if (bus.core_hash_valid) begin
                        res_hash_q  <= bus.core_hash;
                        res_id_q    <= tag;
                        res_valid_q <= 1'b1;
`ifdef MD5_ARB_TIMEOUT_EN
                        timed_out   <= 1'b0;
`endif
                        state       <= DELIVER;
                    end
`ifdef MD5_ARB_TIMEOUT_EN
                    else if (32'(wait_cnt) == TIMEOUT_CYCLES - 32'd1) begin
                        res_hash_q  <= '0;
                        res_id_q    <= tag;
                        res_valid_q <= 1'b1;
                        timed_out   <= 1'b1;
                        state       <= DELIVER;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                DELIVER: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
`ifdef MD5_ARB_TIMEOUT_EN
                        if (!timed_out) jobs_q <= jobs_q + 32'd1;
                        timed_out   <= 1'b0;
`else
                        jobs_q      <= jobs_q + 32'd1;
`endif
                        rr_ptr      <= next_ptr(tag, NREQ);
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.core_msg   = core_job.msg;
    assign bus.core_width = core_job.width;
    assign bus.core_valid = core_valid_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_hash   = res_hash_q;
    assign bus.res_id     = res_id_q;
    assign bus.jobs_done  = jobs_q;

endmodule

// File: tb/tb_md5_arbiter.sv
// Randomized scoreboard bench for md5_arbiter; timeout scenarios run when MD5_ARB_TIMEOUT_EN is defined.
module tb_md5_arbiter;
    import md5_pkg::*;

    localparam int unsigned NREQ = 4;
`ifdef MD5_ARB_TIMEOUT_EN
    localparam int unsigned TO = 16;
`else
    localparam int unsigned TO = 255;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    md5_arbiter_if #(.NREQ(NREQ)) bus ();

    md5_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [2:0]   id;
        logic [127:0] hash;
        logic         timeout;
    } exp_t;

    exp_t expq[$];
    int tests = 0;
    int fails = 0;

    // Stimulus knobs shared by the sequencer and the requester/core driver.
    logic [NREQ-1:0] want = '0;
    bit cont = 1'b0, silent = 1'b0, res_hold = 1'b0, junk_idle = 1'b0, mbusy = 1'b0;
    int lat_min = 1, lat_max = 8;

    logic [127:0] rmsg [NREQ];
    logic [7:0]   rw   [NREQ];
    for (genvar g = 0; g < int'(NREQ); g++) begin : g_pack
        assign bus.req_msg[g*128 +: 128] = rmsg[g];
        assign bus.req_width[g*8 +: 8]   = rw[g];
    end

    function automatic logic [127:0] mix(input logic [127:0] m, input logic [7:0] w);
        return {m[63:0], m[127:64]} ^ {16{w}} ^ 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Requesters and a fake MD5 core, driven on the falling edge.
    initial begin : driver
        int core_cnt;
        logic [127:0] hmsg;
        logic [7:0] hw;
        core_cnt = 0;
        hmsg = '0;
        hw = '0;
        bus.req_valid = '0;
        bus.core_hash_valid = 1'b0;
        bus.core_hash = '0;
        bus.res_ready = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin rmsg[i] = '0; rw[i] = '0; end
        forever begin
            @(negedge clk);
            for (int i = 0; i < int'(NREQ); i++) begin
                if (!want[i] || (bus.req_ready[i] && !cont)) bus.req_valid[i] = 1'b0;
                else if (bus.req_ready[i] || (!bus.req_valid[i] && (cont || $urandom_range(0, 2) == 0))) begin
                    bus.req_valid[i] = 1'b1;
                    rmsg[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
                    rw[i] = 8'($urandom());
                end
            end
            bus.core_hash_valid = 1'b0;
            if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    bus.core_hash_valid = 1'b1;
                    bus.core_hash = mix(hmsg, hw);
                end
            end else if (junk_idle || (bus.res_valid && $urandom_range(0, 3) == 0)) begin
                bus.core_hash_valid = 1'b1;
                bus.core_hash = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            if (bus.core_valid) begin
                hmsg = bus.core_msg;
                hw = bus.core_width;
                core_cnt = silent ? 0 : int'($urandom_range(lat_min, lat_max));
            end
            bus.res_ready = res_hold ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor: reference arbitration model plus result scoreboard, sampled 2 ns after the edge.
    initial begin : monitor
        bit prev_rv, exp_cv, issued, have_g;
        int mptr, wait_n, g;
        logic [31:0] mjobs;
        logic [NREQ-1:0] exp_rr;
        logic [127:0] gmsg, hold_hash;
        logic [7:0] gw;
        logic [2:0] hold_id;
        exp_t cur;
        prev_rv = 0; exp_cv = 0; issued = 0; have_g = 0;
        mptr = 0; wait_n = 0; mjobs = '0; gmsg = '0; gw = '0; hold_hash = '0; hold_id = '0;
        cur = '{id: '0, hash: '0, timeout: 1'b0};
        forever begin
            @(posedge clk);
            #2;
            if (!reset_n) begin
                mbusy = 0; prev_rv = 0; exp_cv = 0; issued = 0; have_g = 0;
                mptr = 0; mjobs = '0;
                expq.delete();
                check("reset_ctl", 128'({bus.req_ready, bus.core_valid, bus.res_valid, bus.res_timeout,
                                         bus.res_id, bus.core_width, bus.jobs_done}), '0);
                check("reset_core_msg", bus.core_msg, '0);
                check("reset_res_hash", bus.res_hash, '0);
                continue;
            end
            if (issued && !prev_rv && !bus.res_valid) wait_n++;
            else if (issued && !prev_rv) wait_n++;
            check("core_valid", 128'(bus.core_valid), 128'(exp_cv));
            if (exp_cv) begin issued = 1; wait_n = 0; exp_cv = 0; end
            // Grant: first pending requester at or after the pointer, only when idle and core ready.
            exp_rr = '0;
            g = -1;
            if (!mbusy && bus.core_ready)
                for (int k = 0; k < int'(NREQ); k++)
                    if (g < 0 && bus.req_valid[(mptr + k) % int'(NREQ)]) g = (mptr + k) % int'(NREQ);
            if (g >= 0) exp_rr[g] = 1'b1;
            check("req_ready", 128'(bus.req_ready), 128'(exp_rr));
            if (g >= 0) begin
                mbusy = 1; exp_cv = 1; have_g = 1;
                gmsg = rmsg[g];
                gw = rw[g];
                expq.push_back('{id: 3'(g), hash: silent ? 128'd0 : mix(rmsg[g], rw[g]), timeout: silent});
            end
            if (have_g) begin
                check("core_msg", bus.core_msg, gmsg);
                check("core_width", 128'(bus.core_width), 128'(gw));
            end
            // Results.
            if (prev_rv) begin
                if (bus.res_ready) begin
                    check("res_release", 128'(bus.res_valid), 0);
                    if (!cur.timeout) mjobs = mjobs + 32'd1;
                    mptr = (int'(cur.id) + 1) % int'(NREQ);
                    mbusy = 0; issued = 0;
                end else begin
                    check("res_hold", 128'(bus.res_valid), 1);
                    check("res_hash_stable", bus.res_hash, hold_hash);
                    check("res_id_stable", 128'(bus.res_id), 128'(hold_id));
                end
            end else if (bus.res_valid) begin
                if (expq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_result: res_valid=1 with id %0d, no job outstanding", bus.res_id);
                end else begin
                    cur = expq.pop_front();
                    check("res_id", 128'(bus.res_id), 128'(cur.id));
                    check("res_hash", bus.res_hash, cur.hash);
                    check("res_timeout", 128'(bus.res_timeout), 128'(cur.timeout));
                    if (cur.timeout) check("timeout_cycles", 128'(wait_n), 128'(TO));
                    else check("digest_latency", 128'(bus.core_hash_valid), 1);
                end
                hold_hash = bus.res_hash;
                hold_id = bus.res_id;
            end
            check("jobs_done", 128'(bus.jobs_done), 128'(mjobs));
            prev_rv = bus.res_valid;
        end
    end

    task automatic wait_rr(input int budget);
        int n = 0;
        while (bus.req_ready == '0 && n < budget) begin @(negedge clk); n++; end
        if (bus.req_ready == '0) begin
            tests++; fails++;
            $display("FAIL wait_grant: no req_ready within %0d cycles", budget);
        end
    endtask

    task automatic wait_quiet(input int budget);
        int n = 0;
        while ((mbusy || bus.req_valid != '0) && n < budget) begin @(negedge clk); n++; end
        if (mbusy || bus.req_valid != '0) begin
            tests++; fails++;
            $display("FAIL wait_quiet: arbiter still busy after %0d cycles", budget);
        end
    endtask

    initial begin : sequencer
        bus.core_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        // Single request with a slow core.
        lat_min = (TO > 70) ? 70 : 10; lat_max = lat_min;
        want = 4'b0001; wait_rr(20); want = '0; wait_quiet(400);
        // All four requesting continuously.
        lat_min = 1; lat_max = 4; cont = 1; want = '1;
        repeat (120) @(negedge clk);
        want = '0; cont = 0; wait_quiet(200);
        // Core not ready: no grant, stray digests while idle.
        bus.core_ready = 1'b0; junk_idle = 1; cont = 1; want = 4'b0100;
        repeat (10) @(negedge clk);
        junk_idle = 0; bus.core_ready = 1'b1;
        wait_rr(3); want = '0; cont = 0; wait_quiet(100);
        // Result held by the consumer.
        res_hold = 1; lat_min = 1; lat_max = 3; cont = 1; want = 4'b0011;
        repeat (40) @(negedge clk);
        res_hold = 0;
        repeat (30) @(negedge clk);
        want = '0; cont = 0; wait_quiet(200);
        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (c % 25 == 0) begin
                want = NREQ'($urandom());
                cont = 1'($urandom_range(0, 1));
                lat_max = int'($urandom_range(1, 10));
            end
            bus.core_ready = ($urandom_range(0, 3) != 0);
        end
        bus.core_ready = 1'b1; want = '0; cont = 0; wait_quiet(200);
`ifdef MD5_ARB_TIMEOUT_EN
        // Silent core times out; then a digest exactly on the last WAIT cycle.
        silent = 1; want = 4'b0001; wait_rr(10); want = '0; wait_quiet(100); silent = 0;
        lat_min = int'(TO) - 1; lat_max = lat_min;
        want = 4'b0010; wait_rr(10); want = '0; wait_quiet(100);
`endif
        // Reset in the middle of WAIT, digest arrives afterwards.
        lat_min = 20; lat_max = 20;
        want = 4'b0001; wait_rr(10); want = '0;
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        check("post_reset_res_valid", 128'(bus.res_valid), 0);
        check("post_reset_jobs_done", 128'(bus.jobs_done), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
